// File: rtl/simu_trig_pkg.sv
// Shared definitions for the simulated trigger generator: channel state
// encodings, run-mode constants and a small config helper.
package simu_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_BURST    = 2'd2;

    // Pulse width and burst length of zero both behave as one.
    function automatic logic [7:0] at_least_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/simu_trig_chan.sv
// One trigger channel: IDLE -> WAIT -> HIGH -> {WAIT | IDLE} with latched
// configuration. The channel index only shifts the first wait by IDX*STAGGER.
module simu_trig_chan
    import simu_trig_pkg::*;
#(
    parameter int CW      = 16,
    parameter int IDX     = 0,
    parameter int STAGGER = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ena,
    input  logic [1:0]    i_mode,
    input  logic [CW-1:0] i_interval,
    input  logic [7:0]    i_width,
    input  logic [7:0]    i_burst_len,
    input  logic          i_chan_en,
    input  logic          i_arm,
    input  logic          i_abort,
    output logic          o_trig,
    output logic          o_trig_d,
    output logic          o_busy,
    output logic          o_start
);

    localparam int              TW       = CW + 8;
    localparam logic [TW-1:0]   STAG_OFS = TW'(IDX * STAGGER);
    localparam logic [TW-1:0]   ONE      = TW'(32'd1);

    state_e          r_state;
    logic [TW-1:0]   r_wcnt;
    logic [TW-1:0]   r_target;
    logic [7:0]      r_hcnt;
    logic [7:0]      r_width;
    logic [7:0]      r_rem;
    logic [1:0]      r_mode;
    logic [CW-1:0]   r_interval;
    logic            r_trig;
    logic            r_busy;

    state_e          w_state_d;
    logic            w_arm_ok;
    logic            w_start;
    logic            w_leave;
    logic            w_again;
    logic            w_run;

    // Next-state decode; abort beats everything, ena=0 freezes the channel.
    always_comb begin
        w_run     = i_ena && !i_abort;
        w_arm_ok  = (r_state == ST_IDLE) && i_arm && i_chan_en && w_run;
        w_start   = (r_state == ST_WAIT) && w_run && (r_wcnt == r_target);
        w_leave   = (r_state == ST_HIGH) && w_run && (r_hcnt == r_width);
        case (r_mode)
            MODE_PERIODIC: w_again = 1'b1;
            MODE_BURST:    w_again = (r_rem != 8'd0);
            default:       w_again = 1'b0;
        endcase
        w_state_d = r_state;
        if (i_abort) begin
            w_state_d = ST_IDLE;
        end else if (w_arm_ok) begin
            w_state_d = ST_WAIT;
        end else if (w_start) begin
            w_state_d = ST_HIGH;
        end else if (w_leave) begin
            w_state_d = w_again ? ST_WAIT : ST_IDLE;
        end else begin
            w_state_d = r_state;
        end
        o_trig_d = w_run && (w_state_d == ST_HIGH);
    end

    // Channel FSM, config latch and wait/high/burst counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= {TW{1'b0}};
            r_target   <= {TW{1'b0}};
            r_hcnt     <= 8'd0;
            r_width    <= 8'd0;
            r_rem      <= 8'd0;
            r_mode     <= 2'd0;
            r_interval <= {CW{1'b0}};
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_busy  <= (w_state_d != ST_IDLE);
            r_trig  <= o_trig_d;
            if (w_arm_ok) begin
                r_mode     <= i_mode;
                r_interval <= i_interval;
                r_width    <= at_least_one(i_width);
                r_rem      <= at_least_one(i_burst_len);
                r_wcnt     <= {TW{1'b0}};
                r_target   <= TW'(i_interval) + STAG_OFS;
            end else if (w_start) begin
                r_hcnt <= 8'd1;
                r_rem  <= r_rem - 8'd1;
            end else if (w_leave) begin
                // Later gaps drop the stagger and use the plain interval.
                r_wcnt   <= {TW{1'b0}};
                r_target <= TW'(r_interval);
            end else if (w_run && (r_state == ST_WAIT)) begin
                r_wcnt <= r_wcnt + ONE;
            end else if (w_run && (r_state == ST_HIGH)) begin
                r_hcnt <= r_hcnt + 8'd1;
            end
        end
    end

    assign o_trig  = r_trig;
    assign o_busy  = r_busy;
    assign o_start = w_start;

endmodule

// File: rtl/simu_trig_gen.sv
// Multi-channel simulated trigger generator: NCH independent pulse channels,
// a registered OR of their triggers and a saturating count of pulse starts.
module simu_trig_gen
    import simu_trig_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CW      = 16,
    parameter int STAGGER = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [1:0]     mode,
    input  logic [CW-1:0]  interval,
    input  logic [7:0]     width,
    input  logic [7:0]     burst_len,
    input  logic [NCH-1:0] chan_en,
    input  logic [NCH-1:0] arm,
    input  logic           abort,
    input  logic           clr_cnt,
    output logic [NCH-1:0] trigger,
    output logic           trig_or,
    output logic [NCH-1:0] busy,
    output logic [CW-1:0]  pulse_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    if ((NCH - 1) * STAGGER > 255) begin : g_bad_stagger
        $error("simu_trig_gen: (NCH-1)*STAGGER must not exceed 255");
    end

    logic [NCH-1:0] w_trig;
    logic [NCH-1:0] w_trig_d;
    logic [NCH-1:0] w_busy;
    logic [NCH-1:0] w_start;
    logic [CW:0]    w_sum;
    logic           r_trig_or;
    logic [CW-1:0]  r_pulse_cnt;

    function automatic logic [CW:0] popcnt(input logic [NCH-1:0] v);
        logic [CW:0] n;
        n = {(CW+1){1'b0}};
        for (int i = 0; i < NCH; i++) begin
            n = n + {{CW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        simu_trig_chan #(
            .CW      (CW),
            .IDX     (k),
            .STAGGER (STAGGER)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_ena       (ena),
            .i_mode      (mode),
            .i_interval  (interval),
            .i_width     (width),
            .i_burst_len (burst_len),
            .i_chan_en   (chan_en[k]),
            .i_arm       (arm[k]),
            .i_abort     (abort),
            .o_trig      (w_trig[k]),
            .o_trig_d    (w_trig_d[k]),
            .o_busy      (w_busy[k]),
            .o_start     (w_start[k])
        );
    end

    assign w_sum = {1'b0, r_pulse_cnt} + popcnt(w_start);

    // trig_or registered from the same next values as the channel triggers; count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trig_or   <= 1'b0;
            r_pulse_cnt <= {CW{1'b0}};
        end else begin
            r_trig_or <= |w_trig_d;
            if (clr_cnt) begin
                r_pulse_cnt <= {CW{1'b0}};
            end else if (w_sum[CW]) begin
                r_pulse_cnt <= CNT_MAX;
            end else begin
                r_pulse_cnt <= w_sum[CW-1:0];
            end
        end
    end

    assign trigger   = w_trig;
    assign busy      = w_busy;
    assign trig_or   = r_trig_or;
    assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_simu_trig_gen.sv
// Bench for simu_trig_gen: a staggered 16-bit instance and a 4-bit-counter
// instance share stimulus; a countdown model predicts both every cycle.
module tb_simu_trig_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0, abort = 1'b0, clr_cnt = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] interval = 16'd0;
    logic [7:0]  width = 8'd0, burst_len = 8'd0;
    logic [3:0]  chan_en = 4'd0, arm = 4'd0;
    logic [3:0]  a_trig, a_busy, b_trig, b_busy, b_cnt;
    logic        a_or, b_or;
    logic [15:0] a_cnt;
    wire  [24:0] a_obs = {a_trig, a_busy, a_or, a_cnt};
    wire  [12:0] b_obs = {b_trig, b_busy, b_or, b_cnt};
    int checks = 0, passed = 0;

    // Model: per channel, cycles left in the current phase and pulses left.
    bit   m_act[2][4], m_high[2][4];
    int   m_left[2][4], m_pl[2][4], m_mode[2][4], m_int[2][4], m_wid[2][4];
    int   m_cnt[2];
    logic [3:0] m_trig[2], m_busy[2];
    int   stg[2]  = '{5, 0};
    int   cmax[2] = '{65535, 15};

    simu_trig_gen #(.NCH(4), .CW(16), .STAGGER(5)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .interval(interval),
        .width(width), .burst_len(burst_len), .chan_en(chan_en), .arm(arm),
        .abort(abort), .clr_cnt(clr_cnt), .trigger(a_trig), .trig_or(a_or),
        .busy(a_busy), .pulse_cnt(a_cnt));

    simu_trig_gen #(.NCH(4), .CW(4), .STAGGER(0)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .interval(interval[3:0]),
        .width(width), .burst_len(burst_len), .chan_en(chan_en), .arm(arm),
        .abort(abort), .clr_cnt(clr_cnt), .trigger(b_trig), .trig_or(b_or),
        .busy(b_busy), .pulse_cnt(b_cnt));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                m_act[d][k] = 1'b0; m_high[d][k] = 1'b0; m_left[d][k] = 0;
            end
            m_cnt[d] = 0; m_trig[d] = 4'd0; m_busy[d] = 4'd0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int starts = 0;
            for (int k = 0; k < 4; k++) begin
                if (abort) begin
                    m_act[d][k] = 1'b0; m_high[d][k] = 1'b0;
                end else if (ena) begin
                    if (!m_act[d][k]) begin
                        if (arm[k] && chan_en[k]) begin
                            m_act[d][k]  = 1'b1; m_high[d][k] = 1'b0;
                            m_mode[d][k] = int'(mode);
                            m_int[d][k]  = int'(interval);
                            m_wid[d][k]  = (width == 8'd0) ? 1 : int'(width);
                            m_pl[d][k]   = (burst_len == 8'd0) ? 1 : int'(burst_len);
                            m_left[d][k] = int'(interval) + k * stg[d] + 1;
                        end
                    end else begin
                        m_left[d][k]--;
                        if (m_left[d][k] == 0) begin
                            if (!m_high[d][k]) begin
                                m_high[d][k] = 1'b1; m_left[d][k] = m_wid[d][k];
                                m_pl[d][k]--; starts++;
                            end else if (m_mode[d][k] == 1 || (m_mode[d][k] == 2 && m_pl[d][k] > 0)) begin
                                m_high[d][k] = 1'b0; m_left[d][k] = m_int[d][k] + 1;
                            end else begin
                                m_act[d][k] = 1'b0; m_high[d][k] = 1'b0;
                            end
                        end
                    end
                end
                m_trig[d][k] = ena && !abort && m_act[d][k] && m_high[d][k];
                m_busy[d][k] = m_act[d][k];
            end
            if (clr_cnt) m_cnt[d] = 0;
            else m_cnt[d] = (m_cnt[d] + starts > cmax[d]) ? cmax[d] : m_cnt[d] + starts;
        end
    endtask

    function automatic logic [37:0] expv();
        return {m_trig[0], m_busy[0], |m_trig[0], 16'(m_cnt[0]),
                m_trig[1], m_busy[1], |m_trig[1], 4'(m_cnt[1])};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_all();
        abort = 1'b1; clr_cnt = 1'b1; arm = 4'd0; ena = 1'b1;
        tick();
        abort = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({a_obs, b_obs} !== 38'd0) $display("FAIL reset_hold got %h exp 0", {a_obs, b_obs});
        else passed++;
        #9 rst = 1'b1;
        model_reset();
        tick();
        checks++;
        if ({a_obs, b_obs} !== expv()) $display("FAIL reset_after got %h exp %h", {a_obs, b_obs}, expv());
        else passed++;
    endtask

    task automatic test_single();
        idle_all();
        mode = 2'd0; interval = 16'd10; width = 8'd9; chan_en = 4'b0001; arm = 4'b0001;
        tick();
        arm = 4'd0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            checks++;
            if ({a_trig[0], a_busy[0]} !== {1'(e >= 11 && e <= 19), 1'(e < 20)})
                $display("FAIL single_edge e=%0d got trig/busy %b%b", e, a_trig[0], a_busy[0]);
            else passed++;
            checks++;
            if ({a_obs, b_obs} !== expv()) $display("FAIL single_model e=%0d got %h exp %h", e, {a_obs, b_obs}, expv());
            else passed++;
        end
        checks++;
        if (a_cnt !== 16'd1) $display("FAIL single_cnt got %0d exp 1", a_cnt);
        else passed++;
    endtask

    task automatic test_periodic_abort();
        int rises[$];
        logic prev = 1'b0;
        bit hit = 1'b0;
        idle_all();
        mode = 2'd1; interval = 16'd3; width = 8'd2; chan_en = 4'b0001; arm = 4'b0001;
        tick();
        arm = 4'd0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (a_trig[0] && !prev) rises.push_back(e);
            prev = a_trig[0];
            checks++;
            if ({a_obs, b_obs} !== expv()) $display("FAIL periodic_model e=%0d got %h exp %h", e, {a_obs, b_obs}, expv());
            else passed++;
        end
        checks++;
        if (rises.size() < 4 || rises[1] - rises[0] != 6 || rises[3] - rises[2] != 6)
            $display("FAIL periodic_period got %p exp spacing 6", rises);
        else passed++;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (a_trig[0]) hit = 1'b1;
            else tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (!hit || {a_trig, a_busy, b_trig, b_busy} !== 16'd0)
            $display("FAIL abort_high got trig/busy %h hit=%0d exp 0", {a_trig, a_busy, b_trig, b_busy}, hit);
        else passed++;
    endtask

    task automatic test_burst();
        int first[4] = '{-1, -1, -1, -1};
        idle_all();
        mode = 2'd2; interval = 16'd2; width = 8'd1; burst_len = 8'd4; chan_en = 4'hF; arm = 4'hF;
        tick();
        arm = 4'd0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            for (int k = 0; k < 4; k++) if (a_trig[k] && first[k] < 0) first[k] = e;
            checks++;
            if ({a_obs, b_obs} !== expv()) $display("FAIL burst_model e=%0d got %h exp %h", e, {a_obs, b_obs}, expv());
            else passed++;
        end
        checks++;
        if (a_cnt !== 16'd16 || a_busy !== 4'd0) $display("FAIL burst_total got cnt=%0d busy=%b exp 16/0", a_cnt, a_busy);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (first[k] !== 3 + 5 * k) $display("FAIL burst_stagger ch%0d got %0d exp %0d", k, first[k], 3 + 5 * k);
            else passed++;
        end
    endtask

    task automatic test_ena_gap();
        int first = -1, highs = 0;
        idle_all();
        mode = 2'd0; interval = 16'd4; width = 8'd6; chan_en = 4'b0001; arm = 4'b0001;
        tick();
        arm = 4'd0;
        for (int e = 1; e <= 25; e++) begin
            ena = !((e >= 2 && e <= 4) || (e >= 10 && e <= 12));
            tick();
            if (a_trig[0]) begin
                highs++;
                if (first < 0) first = e;
            end
            checks++;
            if ({a_obs, b_obs} !== expv()) $display("FAIL enagap_model e=%0d got %h exp %h", e, {a_obs, b_obs}, expv());
            else passed++;
        end
        ena = 1'b1;
        checks++;
        if (first !== 8 || highs !== 6) $display("FAIL enagap_width got rise=%0d high=%0d exp 8/6", first, highs);
        else passed++;
    endtask

    task automatic test_saturation();
        bit found = 1'b0;
        idle_all();
        mode = 2'd1; interval = 16'd1; width = 8'd1; chan_en = 4'b0001; arm = 4'b0001;
        tick();
        arm = 4'd0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            checks++;
            if ({a_obs, b_obs} !== expv()) $display("FAIL sat_model e=%0d got %h exp %h", e, {a_obs, b_obs}, expv());
            else passed++;
        end
        checks++;
        if (b_cnt !== 4'd15 || a_cnt !== 16'd20) $display("FAIL sat_hold got b=%0d a=%0d exp 15/20", b_cnt, a_cnt);
        else passed++;
        for (int i = 0; i < 6 && !found; i++) begin
            if (m_act[1][0] && !m_high[1][0] && m_left[1][0] == 1) begin
                found = 1'b1;
                clr_cnt = 1'b1;
                tick();
                clr_cnt = 1'b0;
            end else tick();
        end
        checks++;
        if (!found || b_cnt !== 4'd0 || a_cnt !== 16'd0 || b_trig[0] !== 1'b1)
            $display("FAIL sat_clr got b=%0d a=%0d trig=%b found=%0d exp 0/0/1", b_cnt, a_cnt, b_trig[0], found);
        else passed++;
    endtask

    task automatic test_async_reset();
        int holds[2] = '{5, 14};
        for (int h = 0; h < 2; h++) begin
            idle_all();
            mode = 2'd0; interval = 16'd10; width = 8'd9; chan_en = 4'b0001; arm = 4'b0001;
            tick();
            arm = 4'd0;
            for (int i = 0; i < holds[h]; i++) tick();
            #2 rst = 1'b0;
            #1;
            checks++;
            if ({a_obs, b_obs} !== 38'd0) $display("FAIL async_reset hold=%0d got %h exp 0", holds[h], {a_obs, b_obs});
            else passed++;
            model_reset();
            #2 rst = 1'b1;
            test_single();
        end
    endtask

    task automatic test_random();
        idle_all();
        for (int e = 0; e < 600; e++) begin
            ena       = ($urandom_range(7) != 0);
            mode      = 2'($urandom_range(3));
            interval  = 16'($urandom_range(6));
            width     = 8'($urandom_range(4));
            burst_len = 8'($urandom_range(4));
            chan_en   = 4'($urandom);
            arm       = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
            abort     = ($urandom_range(40) == 0);
            clr_cnt   = ($urandom_range(30) == 0);
            tick();
            checks++;
            if ({a_obs, b_obs} !== expv()) $display("FAIL random_model e=%0d got %h exp %h", e, {a_obs, b_obs}, expv());
            else passed++;
        end
        abort = 1'b0; clr_cnt = 1'b0; arm = 4'd0; ena = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_periodic_abort();
        test_burst();
        test_ena_gap();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
